// File: rtl/copies_arb_pkg.sv
// copies_arb_pkg
// Shared types and constants for the copies_arbiter slice.
//   arb_state_t : arbiter FSM state encoding (IDLE, GRANT)
//   STATS_WIDTH : width of each per-requester handshake counter, used when
//                 COPIES_ARB_STATS_EN is defined
package copies_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int STATS_WIDTH = 32;

endpackage

// File: rtl/copies_rr_pick.sv
// copies_rr_pick
// Combinational round-robin picker. It returns the first set bit of mask_i,
// searching upward from start_i and wrapping past N_REQ-1 back to 0.
// Ports:
//   mask_i   in  N_REQ     candidate request mask
//   start_i  in  ID_WIDTH  index the search begins at (inclusive)
//   found_o  out 1         some bit of mask_i is set
//   idx_o    out ID_WIDTH  index of the chosen bit (0 when nothing found)
module copies_rr_pick
    import copies_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int ID_WIDTH = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]    mask_i,
    input  logic [ID_WIDTH-1:0] start_i,
    output logic                found_o,
    output logic [ID_WIDTH-1:0] idx_o
);

    // One spare bit so start + offset never overflows before the wrap.
    localparam logic [ID_WIDTH:0] N_L = (ID_WIDTH+1)'(N_REQ);

    logic [ID_WIDTH:0] pos;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = {1'b0, start_i} + (ID_WIDTH+1)'(k);
            if (pos >= N_L) begin
                pos = pos - N_L;
            end
            if (!found_o && mask_i[pos[ID_WIDTH-1:0]]) begin
                found_o = 1'b1;
                idx_o   = pos[ID_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/copies_arbiter.sv
// copies_arbiter
// Round-robin arbiter sharing one copies replication unit among N_REQ
// requesters. The granted requester's (data, count) item is passed straight
// through to copies; the grant is held until copies acknowledges it.
// Optional feature: define COPIES_ARB_STATS_EN to add grant_total, one
// wrapping 32-bit handshake counter per requester.
// Ports:
//   clock        in  1                  clock for all state
//   reset        in  1                  asynchronous active-high reset
//   req_valid    in  N_REQ              per-requester item valid
//   req_ack      out N_REQ              per-requester item accepted
//   req_data     in  N_REQ*DATA_WIDTH   packed item data, slice i = requester i
//   req_count    in  N_REQ*COUNT_WIDTH  packed copy counts, slice i = requester i
//   out_valid    out 1                  item valid to copies.in
//   out_ack      in  1                  item accepted by copies.in
//   out_data     out DATA_WIDTH         item data to copies.in
//   out_count    out COUNT_WIDTH        count to copies.in_count
//   out_id       out ID_WIDTH           index of the granted requester
//   busy         out 1                  high while in GRANT
//   grant_total  out N_REQ*32           per-requester handshake counts (stats build only)
//
// state | meaning
// IDLE  | no grant held; picks next requester from ptr+1 with wrap
// GRANT | requester g owns copies until its item is acknowledged
module copies_arbiter
    import copies_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16,
    parameter int ID_WIDTH    = $clog2(N_REQ)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ack,
    input  logic [N_REQ*DATA_WIDTH-1:0]  req_data,
    input  logic [N_REQ*COUNT_WIDTH-1:0] req_count,
    output logic                         out_valid,
    input  logic                         out_ack,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [COUNT_WIDTH-1:0]       out_count,
    output logic [ID_WIDTH-1:0]          out_id,
`ifdef COPIES_ARB_STATS_EN
    output logic [N_REQ*STATS_WIDTH-1:0] grant_total,
`endif
    output logic                         busy
);

    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(N_REQ - 1);

    arb_state_t          state_q;
    logic [ID_WIDTH-1:0] g_q;
    logic [ID_WIDTH-1:0] ptr_q;

    logic [DATA_WIDTH-1:0]  data_arr [N_REQ];
    logic [COUNT_WIDTH-1:0] cnt_arr  [N_REQ];

    logic                granted;
    logic                hs;
    logic [ID_WIDTH-1:0] idle_start;
    logic [ID_WIDTH-1:0] hs_start;
    logic [N_REQ-1:0]    hs_mask;
    logic                idle_found;
    logic [ID_WIDTH-1:0] idle_idx;
    logic                hs_found;
    logic [ID_WIDTH-1:0] hs_idx;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            cnt_arr[i]  = req_count[i*COUNT_WIDTH +: COUNT_WIDTH];
        end
    end

    assign granted    = (state_q == GRANT);
    assign out_valid  = granted && req_valid[g_q];
    assign hs         = out_valid && out_ack;
    assign busy       = granted;
    assign out_data   = granted ? data_arr[g_q] : '0;
    assign out_count  = granted ? cnt_arr[g_q]  : '0;
    assign out_id     = granted ? g_q           : '0;

    // Only the granted requester can ever see an ack, and only on a real handshake.
    always_comb begin
        req_ack = '0;
        if (hs) begin
            req_ack[g_q] = 1'b1;
        end
    end

    assign idle_start = (ptr_q == LAST_ID) ? '0 : ptr_q + ID_WIDTH'(1);
    assign hs_start   = (g_q == LAST_ID)   ? '0 : g_q + ID_WIDTH'(1);
    // The just-served requester is excluded so it cannot win back-to-back.
    assign hs_mask    = req_valid & ~(N_REQ'(1) << g_q);

    copies_rr_pick #(
        .N_REQ    (N_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick_idle (
        .mask_i  (req_valid),
        .start_i (idle_start),
        .found_o (idle_found),
        .idx_o   (idle_idx)
    );

    copies_rr_pick #(
        .N_REQ    (N_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick_hs (
        .mask_i  (hs_mask),
        .start_i (hs_start),
        .found_o (hs_found),
        .idx_o   (hs_idx)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            g_q     <= '0;
            ptr_q   <= LAST_ID;
        end else begin
            case (state_q)
                IDLE: begin
                    if (idle_found) begin
                        g_q     <= idle_idx;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (hs) begin
                        ptr_q <= g_q;
                        if (hs_found) begin
                            g_q <= hs_idx;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (!req_valid[g_q]) begin
                        // Requester withdrew: give up the grant, keep fairness pointer.
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef COPIES_ARB_STATS_EN
    logic [STATS_WIDTH-1:0] stat_q [N_REQ];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                stat_q[i] <= '0;
            end
        end else if (hs) begin
            stat_q[g_q] <= stat_q[g_q] + STATS_WIDTH'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            grant_total[i*STATS_WIDTH +: STATS_WIDTH] = stat_q[i];
        end
    end
`endif

endmodule
